multicycle_sequencer: RTL
=========================

# multicycle_sequencer

Multi-cycle control state machine that sequences the shared datapath (single memory port, one ALU, register file, PC, instruction register) through fetch, decode, execute, memory and write-back steps. It executes the four-instruction ISA (R-format, load word, store word, branch-if-equal) and replaces per-instruction combinational control with per-cycle control. It sits between the instruction register opcode field / ALU zero flag and every datapath mux and write enable, and owns the memory request/acknowledge handshake.

## Interface
- No parameters; all encodings come from the shared package.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- run  input  1  permits a new instruction fetch; sampled only in FETCH
- opCode  input  6  opcode field of the instruction register; stable from DECODE until the next FETCH
- zero  input  1  ALU zero flag
- memAck  input  1  memory completes the current request this cycle
- memReq  output  1  memory request; held until memAck
- memWrite  output  1  request is a write; valid only with memReq
- iOrD  output  1  memory address select: 0 = PC, 1 = ALU result register
- irWrite  output  1  instruction register load
- pcWrite  output  1  unconditional PC load
- pcSource  output  1  PC input select: 0 = ALU output, 1 = ALU result register (branch target)
- regWrite  output  1  register file write
- regDst  output  1  destination select: 1 = rd, 0 = rt
- memToReg  output  1  write-back data: 1 = memory data, 0 = ALU result register
- aluSrcA  output  1  0 = PC, 1 = register A
- aluSrcB  output  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2
- aluOp  output  2  00 = add, 01 = subtract, 10 = decode funct field
- illegalOp  output  1  sticky: unknown opcode decoded
- state  output  3  current state encoding, for debug
- instrCount  output  16  retired-instruction counter

## Operation
- States: FETCH, DECODE, EXEC, MEM, WRITEBACK, BRANCH, HALT.
- FETCH with run=0: no outputs asserted; stay.
- FETCH with run=1: memReq=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00.
  - memAck=0: stay.
  - memAck=1: irWrite=1 and pcWrite=1 in the same cycle (Mealy); go to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (precomputes branch target).
  - 000000 or 000001 or 000010 go to EXEC.
  - 000011 goes to BRANCH.
  - Any other opcode goes to HALT.
- EXEC, R-format: aluSrcA=1, aluSrcB=00, aluOp=10; go to WRITEBACK.
- EXEC, LW/SW: aluSrcA=1, aluSrcB=10, aluOp=00; go to MEM.
- MEM: memReq=1, iOrD=1, memWrite=1 for SW and 0 for LW; stay until memAck.
  - On ack, LW goes to WRITEBACK and SW retires to FETCH.
- WRITEBACK: regWrite=1.
  - R-format: regDst=1, memToReg=0.
  - LW: regDst=0, memToReg=1.
  - Retires to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSource=1; pcWrite=zero (combinational); retires to FETCH.
- HALT: illegalOp=1; all strobes 0; stay until reset. The instruction does not retire.
- Retire: instrCount increments by 1 on the transition into FETCH from WRITEBACK, MEM (SW) or BRANCH. It wraps 16'hFFFF to 0.
- Every output not listed for a state is 0.

## Timing
- Reset (asynchronous, any state, mid-handshake included):
  - state goes to FETCH immediately; instrCount=0; illegalOp=0.
  - All strobes drop to 0 while rst_n=0.
  - memReq may reassert on the first cycle after release if run=1.
- Latency with zero-wait memory (memAck in the first request cycle):
  - R-format: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - Each memory wait cycle adds one cycle.
- Handshake:
  - memReq, iOrD and memWrite stay constant from the first request cycle through the ack cycle.
  - memAck outside FETCH/MEM is ignored.
- run falling while a FETCH request is outstanding (memReq=1, no ack yet) does not cancel it; the request holds until memAck.
- run does not affect instructions already past FETCH.
- The opCode value used is the one sampled in DECODE. EXEC, MEM and WRITEBACK select their behaviour from a registered copy of it.

## Structure
- Shared package holds:
  - state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ);
  - aluOp encodings and aluSrcB encodings.
- The single-cycle decoder uses the same opcode constants.
- Implemented as one module: a state register, a registered opcode, a combinational output decode and a 16-bit counter. No sub-module.

## Test plan
- Reset, run=1, memAck tied high, opCode=000000, zero=0 -> state sequence FETCH, DECODE, EXEC, WRITEBACK, FETCH. regWrite=1 and regDst=1 only in WRITEBACK. instrCount=1 after 4 cycles.
- LW with memAck delayed 2 cycles in both FETCH and MEM -> memReq held steady for 3 cycles each time. irWrite pulses exactly once. Write-back has memToReg=1, regDst=0. Total 9 cycles.
- SW then BEQ with zero=1, then BEQ with zero=0 -> memWrite=1 only in the SW MEM cycle. pcWrite is 1 in the first BRANCH and 0 in the second. instrCount=3.
- opCode=111111 -> HALT reached 2 cycles after fetch ack, illegalOp=1, no strobes asserted for 20 cycles. rst_n pulse clears illegalOp and returns to FETCH.
- Preload instrCount to 16'hFFFF by running 65535 instructions, retire one more -> instrCount=0. Assert rst_n=0 mid-MEM -> memReq drops asynchronously and state=FETCH.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - shared encodings for the multi-cycle control sequencer
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXEC      = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_BRANCH    = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b000001;
  localparam logic [5:0] OP_SW    = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

endpackage

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - per-cycle control FSM for the shared multi-cycle datapath
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  opCode,
  input  logic        zero,
  input  logic        memAck,
  output logic        memReq,
  output logic        memWrite,
  output logic        iOrD,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        pcSource,
  output logic        regWrite,
  output logic        regDst,
  output logic        memToReg,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic        illegalOp,
  output logic [2:0]  state,
  output logic [15:0] instrCount
);

  state_t      state_q, state_next;
  logic [5:0]  op_q;
  logic        fetch_pend;
  logic        retire;
  logic [15:0] instr_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      op_q          <= OP_RTYPE;
      fetch_pend    <= 1'b0;
      instr_count_q <= 16'd0;
    end else begin
      state_q    <= state_next;
      fetch_pend <= (state_q == S_FETCH) && memReq && !memAck;
      if (state_q == S_DECODE) op_q <= opCode;
      if (retire) instr_count_q <= instr_count_q + 16'd1;
    end
  end

  // Strobes are qualified by rst_n so they fall as soon as reset asserts.
  always_comb begin
    state_next = state_q;
    retire     = 1'b0;
    memReq     = 1'b0;
    memWrite   = 1'b0;
    iOrD       = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSource   = 1'b0;
    regWrite   = 1'b0;
    regDst     = 1'b0;
    memToReg   = 1'b0;
    aluSrcA    = 1'b0;
    aluSrcB    = SRCB_REG;
    aluOp      = ALU_ADD;
    illegalOp  = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          // An outstanding fetch request survives run dropping.
          if (run || fetch_pend) begin
            memReq  = 1'b1;
            aluSrcB = SRCB_FOUR;
            if (memAck) begin
              irWrite    = 1'b1;
              pcWrite    = 1'b1;
              state_next = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          aluSrcB = SRCB_IMM_SHL2;
          case (opCode)
            OP_RTYPE, OP_LW, OP_SW: state_next = S_EXEC;
            OP_BEQ:                 state_next = S_BRANCH;
            default:                state_next = S_HALT;
          endcase
        end
        S_EXEC: begin
          aluSrcA = 1'b1;
          if (op_q == OP_RTYPE) begin
            aluOp      = ALU_FUNCT;
            state_next = S_WRITEBACK;
          end else begin
            aluSrcB    = SRCB_IMM;
            state_next = S_MEM;
          end
        end
        S_MEM: begin
          memReq   = 1'b1;
          iOrD     = 1'b1;
          memWrite = (op_q == OP_SW);
          if (memAck) begin
            if (op_q == OP_SW) begin
              retire     = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WRITEBACK;
            end
          end
        end
        S_WRITEBACK: begin
          regWrite   = 1'b1;
          memToReg   = (op_q == OP_LW);
          regDst     = (op_q != OP_LW);
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          aluSrcA    = 1'b1;
          aluOp      = ALU_SUB;
          pcSource   = 1'b1;
          pcWrite    = zero;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_HALT: illegalOp = 1'b1;
        default: state_next = S_FETCH;
      endcase
    end
  end

  assign state      = state_q;
  assign instrCount = instr_count_q;

endmodule
